// File: rtl/tx_pkt_pkg.sv
// tx_pkt_pkg: shared definitions for the TX packetizer.
//   state_t     - packetizer FSM states
//   FRAME_LEN   - bytes per frame (SOF, addr, buysell, ts x4, CHK)
//   IDX_W       - byte-index width
//   SOF_DEFAULT - default start-of-frame byte
//   frame_chk() - XOR checksum over the six payload bytes (SOF excluded)
package tx_pkt_pkg;

  localparam int         FRAME_LEN   = 8;
  localparam int         IDX_W       = 3;
  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0]  addr,
                                           input logic [7:0]  buysell,
                                           input logic [31:0] ts);
    return addr ^ buysell ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
  endfunction

endpackage

// File: rtl/tx_packetizer.sv
// tx_packetizer: captures one order message and serialises it as an 8-byte
// frame (SOF, addr, buysell, ts[31:24..7:0], CHK) into a UART byte transmitter,
// one byte per uart_dv strobe, handshaking on uart_busy.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   tx_addr/buysell/timestamp, tx_dv - message in; tx_busy back to the mux
//   uart_data, uart_dv    - byte + one-cycle start strobe to the UART
//   uart_busy             - UART is shifting a byte
//   drop_cnt              - saturating count of messages rejected while busy
//   ack_err_cnt           - saturating count of bytes whose busy never rose
module tx_packetizer
  import tx_pkt_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_addr,
  input  logic [7:0]  tx_buysell,
  input  logic [31:0] tx_timestamp,
  input  logic        tx_dv,
  output logic        tx_busy,
  output logic [7:0]  uart_data,
  output logic        uart_dv,
  input  logic        uart_busy,
  output logic [15:0] drop_cnt,
  output logic [15:0] ack_err_cnt
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t                         r_state, w_next;
  logic [FRAME_LEN-1:0][7:0]      r_frame;
  logic [IDX_W-1:0]               r_idx;
  logic [TMO_W-1:0]               r_tmo;
  logic                           r_busy, r_uart_dv;
  logic [7:0]                     r_uart_data;
  logic [15:0]                    r_drop_cnt, r_ack_err_cnt;

  logic w_capture, w_send, w_tmo_hit, w_advance, w_drop;

  // Anything arriving outside IDLE is rejected; tx_busy mirrors "not IDLE",
  // so this also covers the cycle in which tx_busy first rises.
  assign w_drop = tx_dv && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_send    = 1'b0;
    w_tmo_hit = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_dv) begin
          w_capture = 1'b1;
          w_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!uart_busy) begin
          w_send = 1'b1;
          w_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // The strobe cycle itself is the first WAIT_ACK cycle (uart_dv is
        // registered), so the timeout window is ACK_TIMEOUT cycles from it.
        if (uart_busy) begin
          w_next = ST_WAIT_DONE;
        end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
          w_tmo_hit = 1'b1;
          w_next    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          if (r_idx == IDX_W'(FRAME_LEN - 1)) begin
            w_next = ST_IDLE;
          end else begin
            w_advance = 1'b1;
            w_next    = ST_SEND;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame       <= '0;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_busy        <= 1'b0;
      r_uart_dv     <= 1'b0;
      r_uart_data   <= 8'h00;
      r_drop_cnt    <= '0;
      r_ack_err_cnt <= '0;
    end else begin
      r_busy    <= (w_next != ST_IDLE);
      r_uart_dv <= w_send;

      if (w_capture) begin
        r_frame[0] <= SOF_BYTE;
        r_frame[1] <= tx_addr;
        r_frame[2] <= tx_buysell;
        r_frame[3] <= tx_timestamp[31:24];
        r_frame[4] <= tx_timestamp[23:16];
        r_frame[5] <= tx_timestamp[15:8];
        r_frame[6] <= tx_timestamp[7:0];
        r_frame[7] <= frame_chk(tx_addr, tx_buysell, tx_timestamp);
        r_idx      <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_send) begin
        r_uart_data <= r_frame[r_idx];
        r_tmo       <= '0;
      end else if (r_state == ST_WAIT_ACK) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_tmo_hit && (r_ack_err_cnt != 16'hFFFF))
        r_ack_err_cnt <= r_ack_err_cnt + 16'd1;
    end
  end

  assign tx_busy     = r_busy;
  assign uart_dv     = r_uart_dv;
  assign uart_data   = r_uart_data;
  assign drop_cnt    = r_drop_cnt;
  assign ack_err_cnt = r_ack_err_cnt;

endmodule

// File: tb/tb_tx_packetizer.sv
// tb_tx_packetizer: directed + randomised checks of tx_packetizer against a
// frame-level reference (expected byte list built from the message fields)
// and a simple UART model that stays busy a programmable number of cycles.
module tb_tx_packetizer;

  localparam int ACK_TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_addr, tx_buysell;
  logic [31:0] tx_timestamp;
  logic        tx_dv;
  logic        tx_busy;
  logic [7:0]  uart_data;
  logic        uart_dv;
  logic        uart_busy = 1'b0;
  logic [15:0] drop_cnt, ack_err_cnt;

  always #5 clk = ~clk;

  tx_packetizer #(.SOF_BYTE(8'hAA), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset),
    .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp),
    .tx_dv(tx_dv), .tx_busy(tx_busy),
    .uart_data(uart_data), .uart_dv(uart_dv), .uart_busy(uart_busy),
    .drop_cnt(drop_cnt), .ack_err_cnt(ack_err_cnt)
  );

  // ---------------- UART model ----------------
  int         busy_len  = 10;   // 0 = never acknowledges
  logic       hold_busy = 1'b0;
  int         busy_cnt  = 0;
  int         dv_cnt    = 0;
  int         cyc       = 0;
  logic [7:0] rx_q[$];
  int         dv_t[$];

  always @(negedge clk) begin
    int n;
    n = busy_cnt;
    if (uart_dv) begin
      rx_q.push_back(uart_data);
      dv_t.push_back(cyc);
      if (busy_len > 0) n = busy_len;
    end else if (n > 0) begin
      n = n - 1;
    end
    busy_cnt  <= n;
    uart_busy <= hold_busy || (n > 0);
    dv_cnt    <= dv_cnt + (uart_dv ? 1 : 0);
    cyc       <= cyc + 1;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_drop = '0;
  logic [15:0] exp_ack  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [7:0] a, input logic [7:0] b,
                                            input logic [31:0] ts);
    logic [7:0] c;
    c = a ^ b ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
    return {8'hAA, a, b, ts, c};
  endfunction

  function automatic logic [63:0] rx_packed();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[55:0], (i < rx_q.size()) ? rx_q[i] : 8'h00};
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One-cycle tx_dv; returns in the cycle after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [31:0] ts);
    tx_addr = a; tx_buysell = b; tx_timestamp = ts; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (tx_busy && k < 3000) begin tick(); k++; end
    chk({tag, "_idle_timeout"}, {63'd0, tx_busy}, 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp);
    chk({tag, "_nbytes"}, 64'(rx_q.size()), 64'd8);
    chk({tag, "_bytes"}, rx_packed(), exp);
  endtask

  initial begin
    logic [7:0]  a, b;
    logic [31:0] ts;
    int dv0, k, mode;

    reset = 1'b1; tx_dv = 1'b0;
    tx_addr = '0; tx_buysell = '0; tx_timestamp = '0;
    repeat (3) tick();
    chk("rst_busy",  {63'd0, tx_busy},     64'd0);
    chk("rst_dv",    {63'd0, uart_dv},     64'd0);
    chk("rst_data",  {56'd0, uart_data},   64'd0);
    chk("rst_drop",  {48'd0, drop_cnt},    64'd0);
    chk("rst_ack",   {48'd0, ack_err_cnt}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic frame with latency and strobe-width checks
    busy_len = 10; rx_q.delete(); dv0 = dv_cnt;
    send(8'h05, 8'h01, 32'h12345678);
    chk("basic_busy_rise", {63'd0, tx_busy}, 64'd1);
    chk("basic_dv_early",  {63'd0, uart_dv}, 64'd0);
    tick();
    chk("basic_latency",   {63'd0, uart_dv}, 64'd1);
    tick();
    chk("basic_dv_width",  {63'd0, uart_dv}, 64'd0);
    wait_idle("basic");
    chk("basic_bytes_lit", rx_packed(), 64'hAA05011234567_80C);
    chk("basic_dv_count",  64'(dv_cnt - dv0), 64'd8);
    chk("basic_uart_done", {63'd0, uart_busy}, 64'd0);

    // Second message 3 cycles after the first is dropped
    rx_q.delete();
    send(8'h11, 8'h22, 32'hCAFEF00D);
    tick(); tick();
    tx_addr = 8'hEE; tx_buysell = 8'hDD; tx_timestamp = 32'h0BADBEEF; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0; exp_drop++;
    wait_idle("drop");
    check_frame("drop_frame", exp_frame(8'h11, 8'h22, 32'hCAFEF00D));
    chk("drop_cnt1", {48'd0, drop_cnt}, {48'd0, exp_drop});
    rx_q.delete();
    send(8'h33, 8'h44, 32'h01020304);
    wait_idle("after_drop");
    check_frame("after_drop", exp_frame(8'h33, 8'h44, 32'h01020304));

    // Randomised frames, UART speeds and rejected messages
    for (int it = 0; it < 8; it++) begin
      a = 8'($urandom); b = 8'($urandom); ts = $urandom;
      busy_len = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      rx_q.delete();
      tx_addr = a; tx_buysell = b; tx_timestamp = ts; tx_dv = 1'b1;
      tick();
      if (mode == 1) begin
        // tx_dv held into the cycle tx_busy rises: second beat rejected
        tx_addr = 8'($urandom); tx_buysell = 8'($urandom); tx_timestamp = $urandom;
        tick();
        exp_drop++;
      end
      tx_dv = 1'b0;
      if (mode == 2) begin
        k = $urandom_range(1, 10);
        repeat (k) tick();
        if (tx_busy) begin
          tx_addr = 8'($urandom); tx_buysell = 8'($urandom); tx_timestamp = $urandom;
          tx_dv = 1'b1;
          tick();
          tx_dv = 1'b0;
          exp_drop++;
        end
      end
      wait_idle("rand");
      check_frame("rand_frame", exp_frame(a, b, ts));
      chk("rand_drop", {48'd0, drop_cnt}, {48'd0, exp_drop});
    end

    // ACK timeout: UART never raises busy
    busy_len = 0; rx_q.delete(); dv_t.delete(); dv0 = dv_cnt;
    send(8'h5A, 8'hA5, 32'hDEADBEEF);
    wait_idle("ackto");
    exp_ack += 16'd8;
    chk("ackto_pulses", 64'(dv_cnt - dv0), 64'd8);
    chk("ackto_cnt",    {48'd0, ack_err_cnt}, {48'd0, exp_ack});
    check_frame("ackto_frame", exp_frame(8'h5A, 8'hA5, 32'hDEADBEEF));
    if (dv_t.size() >= 2)
      chk("ackto_period", 64'(dv_t[1] - dv_t[0]), 64'(ACK_TO + 2));
    else
      chk("ackto_period_n", 64'(dv_t.size()), 64'd2);

    // Reset during byte 3
    busy_len = 10; rx_q.delete();
    send(8'h77, 8'h88, 32'h99AABBCC);
    k = 0;
    while (rx_q.size() < 3 && k < 500) begin tick(); k++; end
    chk("rstmid_reach3", 64'(rx_q.size()), 64'd3);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", {63'd0, tx_busy},     64'd0);
    chk("rstmid_dv",   {63'd0, uart_dv},     64'd0);
    chk("rstmid_data", {56'd0, uart_data},   64'd0);
    chk("rstmid_drop", {48'd0, drop_cnt},    64'd0);
    chk("rstmid_ack",  {48'd0, ack_err_cnt}, 64'd0);
    exp_drop = '0; exp_ack = '0;
    dv0 = dv_cnt;
    repeat (4) tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("rstmid_no_dv", 64'(dv_cnt - dv0), 64'd0);
    a = 8'($urandom); b = 8'($urandom); ts = $urandom;
    rx_q.delete();
    send(a, b, ts);
    wait_idle("rstmid_next");
    check_frame("rstmid_next", exp_frame(a, b, ts));

    // drop_cnt saturation
    rx_q.delete();
    send(8'h01, 8'h02, 32'h03040506);
    force dut.r_drop_cnt = 16'hFFFE;
    tick();
    release dut.r_drop_cnt;
    for (int i = 0; i < 3; i++) begin
      tx_dv = 1'b1; tick(); tx_dv = 1'b0; tick();
    end
    chk("sat_drop", {48'd0, drop_cnt}, 64'h0000_0000_0000_FFFF);
    wait_idle("sat");
    check_frame("sat_frame", exp_frame(8'h01, 8'h02, 32'h03040506));
    exp_drop = 16'hFFFF;

    // UART busy at capture: strobe withheld until it frees up
    hold_busy = 1'b1;
    tick(); tick();
    rx_q.delete(); dv0 = dv_cnt;
    send(8'hC3, 8'h3C, 32'h55AA00FF);
    repeat (10) tick();
    chk("ibusy_withheld", 64'(dv_cnt - dv0), 64'd0);
    chk("ibusy_still_busy", {63'd0, tx_busy}, 64'd1);
    hold_busy = 1'b0;
    wait_idle("ibusy");
    check_frame("ibusy_frame", exp_frame(8'hC3, 8'h3C, 32'h55AA00FF));

    chk("final_drop", {48'd0, drop_cnt},    {48'd0, exp_drop});
    chk("final_ack",  {48'd0, ack_err_cnt}, {48'd0, exp_ack});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
